// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered result/flags, iterative one-bit-per-cycle shifts.
// Drop-in successor of the 5-bit combinational datapath ALU (op codes 000-011 compatible).
module alu_seq #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             sf,
  output logic             zf,
  output logic             cf,
  output logic             of
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             right;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             res_cf;
  logic             res_of;
  logic             is_shift;
  logic [CW-1:0]    n;
  logic [WIDTH-1:0] sh_src;
  logic [WIDTH-1:0] sh_val;
  logic             sh_dir;
  logic             sh_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign is_shift  = (op == 3'b010) || (op == 3'b111);

  // Non-shift datapath; only sampled on the accept edge.
  always_comb begin
    sum    = '0;
    res    = '0;
    res_cf = 1'b0;
    res_of = 1'b0;
    case (op)
      3'b000: begin
        sum    = {1'b0, a} + {1'b0, b};
        res    = sum[WIDTH-1:0];
        res_cf = sum[WIDTH];
        res_of = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b100: begin
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        res    = sum[WIDTH-1:0];
        res_cf = ~sum[WIDTH];
        res_of = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001:  res = a | b;
      3'b101:  res = a & b;
      3'b110:  res = a ^ b;
      default: res = '0;
    endcase
  end

  // Shift amount saturates at WIDTH; larger amounts behave identically.
  always_comb begin
    if (b >= WIDTH) n = CW'(WIDTH);
    else            n = CW'(b);
  end

  // One-bit shifter shared by the accept edge (source a) and the SHIFT state (source acc).
  always_comb begin
    sh_src = (state == IDLE) ? a : acc;
    sh_dir = (state == IDLE) ? op[2] : right;
    if (sh_dir) begin
      sh_val = {1'b0, sh_src[WIDTH-1:1]};
      sh_bit = sh_src[0];
    end else begin
      sh_val = {sh_src[WIDTH-2:0], 1'b0};
      sh_bit = sh_src[WIDTH-1];
    end
  end

  // The accept edge performs the first shift step, so a shift of n takes max(n,1) edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      right <= 1'b0;
      r     <= '0;
      sf    <= 1'b0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      of    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift) begin
              right <= op[2];
              if (n == '0) begin
                r     <= a;
                sf    <= a[WIDTH-1];
                zf    <= (a == '0);
                cf    <= 1'b0;
                of    <= 1'b0;
                state <= DONE;
              end else if (n == CW'(1)) begin
                r     <= sh_val;
                sf    <= sh_val[WIDTH-1];
                zf    <= (sh_val == '0);
                cf    <= sh_bit;
                of    <= 1'b0;
                state <= DONE;
              end else begin
                acc   <= sh_val;
                cnt   <= n - CW'(1);
                state <= SHIFT;
              end
            end else begin
              r     <= res;
              sf    <= res[WIDTH-1];
              zf    <= (res == '0);
              cf    <= res_cf;
              of    <= res_of;
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= sh_val;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            r     <= sh_val;
            sf    <= sh_val[WIDTH-1];
            zf    <= (sh_val == '0);
            cf    <= sh_bit;
            of    <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
